// File: rtl/matrix_location_arbiter.sv
// matrix_location_arbiter: round-robin merge of two (layer,row) read streams onto one memory port, with data routed back
module matrix_location_arbiter #(
   parameter int layer_index_size = 32,
   parameter int row_index_size   = 32,
   parameter int data_size        = 32,
   parameter int max_outstanding  = 4
) (
   input  logic                        clk,
   input  logic                        rst_n,
   input  logic                        req_valid_1,
   output logic                        req_ready_1,
   input  logic [layer_index_size-1:0] read_layer_index_1,
   input  logic [row_index_size-1:0]   read_row_index_1,
   input  logic                        req_valid_2,
   output logic                        req_ready_2,
   input  logic [layer_index_size-1:0] read_layer_index_2,
   input  logic [row_index_size-1:0]   read_row_index_2,
   output logic                        read_valid,
   input  logic                        read_ready,
   output logic [layer_index_size-1:0] read_layer_index,
   output logic [row_index_size-1:0]   read_row_index,
   input  logic                        mem_resp_valid,
   input  logic [data_size-1:0]        mem_resp_data,
   output logic                        resp_valid_1,
   output logic [data_size-1:0]        resp_data_1,
   output logic                        resp_valid_2,
   output logic [data_size-1:0]        resp_data_2,
   output logic                        resp_error
);
   localparam int pw = $clog2(max_outstanding);
   localparam int cw = pw + 1;
   localparam logic [cw-1:0] max_cnt = cw'(max_outstanding);

   logic                       pri_2;
   logic [max_outstanding-1:0] tag_mem;
   logic [pw-1:0]              wr_ptr, rd_ptr;
   logic [cw-1:0]              count;
   logic                       can_grant, grant_1, grant_2, push, pop, tag_out;

   // grant decision; the full check uses the pre-pop count, so a same-cycle response does not free a slot
   always_comb begin
      can_grant = (!read_valid || read_ready) && (count < max_cnt);
      grant_1   = can_grant && req_valid_1 && (!req_valid_2 || !pri_2);
      grant_2   = can_grant && req_valid_2 && (!req_valid_1 || pri_2);
      push      = grant_1 || grant_2;
      pop       = mem_resp_valid && (count != '0);
      tag_out   = tag_mem[rd_ptr];
   end

   assign req_ready_1 = grant_1;
   assign req_ready_2 = grant_2;

   // round-robin pointer and registered memory-side location
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         pri_2            <= 1'b0;
         read_valid       <= 1'b0;
         read_layer_index <= '0;
         read_row_index   <= '0;
      end else if (push) begin
         pri_2            <= grant_1;
         read_valid       <= 1'b1;
         read_layer_index <= grant_1 ? read_layer_index_1 : read_layer_index_2;
         read_row_index   <= grant_1 ? read_row_index_1 : read_row_index_2;
      end else if (read_ready) begin
         read_valid       <= 1'b0;
      end
   end

   // tag FIFO remembering which requester owns each outstanding read, in issue order
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         tag_mem <= '0;
         wr_ptr  <= '0;
         rd_ptr  <= '0;
         count   <= '0;
      end else begin
         if (push) tag_mem[wr_ptr] <= grant_2;
         wr_ptr <= push ? wr_ptr + pw'(1) : wr_ptr;
         rd_ptr <= pop ? rd_ptr + pw'(1) : rd_ptr;
         count  <= (push && !pop) ? count + cw'(1) : (!push && pop) ? count - cw'(1) : count;
      end
   end

   // route returned words to their owner; an unexpected word is dropped and flagged
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         resp_valid_1 <= 1'b0;
         resp_valid_2 <= 1'b0;
         resp_data_1  <= '0;
         resp_data_2  <= '0;
         resp_error   <= 1'b0;
      end else begin
         resp_valid_1 <= pop && !tag_out;
         resp_valid_2 <= pop && tag_out;
         if (pop && !tag_out) resp_data_1 <= mem_resp_data;
         if (pop && tag_out) resp_data_2 <= mem_resp_data;
         resp_error   <= resp_error || (mem_resp_valid && count == '0);
      end
   end
endmodule

// File: tb/tb_matrix_location_arbiter.sv
// tb_matrix_location_arbiter: directed checks of arbitration, back-pressure, routing, error and reset
module tb_matrix_location_arbiter;
   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        req_valid_1 = 1'b0, req_valid_2 = 1'b0;
   logic        req_ready_1, req_ready_2;
   logic [31:0] read_layer_index_1 = '0, read_row_index_1 = '0;
   logic [31:0] read_layer_index_2 = '0, read_row_index_2 = '0;
   logic        read_valid;
   logic        read_ready = 1'b1;
   logic [31:0] read_layer_index, read_row_index;
   logic        mem_resp_valid = 1'b0;
   logic [31:0] mem_resp_data = '0;
   logic        resp_valid_1, resp_valid_2, resp_error;
   logic [31:0] resp_data_1, resp_data_2;
   int          n_cmp = 0;
   int          n_err = 0;

   matrix_location_arbiter dut (
      .clk(clk), .rst_n(rst_n),
      .req_valid_1(req_valid_1), .req_ready_1(req_ready_1),
      .read_layer_index_1(read_layer_index_1), .read_row_index_1(read_row_index_1),
      .req_valid_2(req_valid_2), .req_ready_2(req_ready_2),
      .read_layer_index_2(read_layer_index_2), .read_row_index_2(read_row_index_2),
      .read_valid(read_valid), .read_ready(read_ready),
      .read_layer_index(read_layer_index), .read_row_index(read_row_index),
      .mem_resp_valid(mem_resp_valid), .mem_resp_data(mem_resp_data),
      .resp_valid_1(resp_valid_1), .resp_data_1(resp_data_1),
      .resp_valid_2(resp_valid_2), .resp_data_2(resp_data_2),
      .resp_error(resp_error)
   );

   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      rst_n = 1'b0;
      tick();
      rst_n = 1'b1;
      #1;
   endtask

   task automatic test_reset();
      #2;
      n_cmp++; if ({read_valid, resp_valid_1, resp_valid_2, resp_error} !== 4'b0) begin n_err++; $display("FAIL reset_flags: got %b expected 0000", {read_valid, resp_valid_1, resp_valid_2, resp_error}); end
      n_cmp++; if ({read_layer_index, read_row_index, resp_data_1, resp_data_2} !== 128'h0) begin n_err++; $display("FAIL reset_data: got %h expected 0", {read_layer_index, read_row_index, resp_data_1, resp_data_2}); end
      tick();
      rst_n = 1'b1;
      #1;
   endtask

   task automatic test_single();
      req_valid_1 = 1'b1; read_layer_index_1 = 3; read_row_index_1 = 7;
      #1;
      n_cmp++; if ({req_ready_1, req_ready_2} !== 2'b10) begin n_err++; $display("FAIL single_ready: got %b expected 10", {req_ready_1, req_ready_2}); end
      tick();
      req_valid_1 = 1'b0;
      n_cmp++; if ({read_valid, read_layer_index, read_row_index} !== {1'b1, 32'd3, 32'd7}) begin n_err++; $display("FAIL single_loc: got %b/%0d/%0d expected 1/3/7", read_valid, read_layer_index, read_row_index); end
      tick();
      n_cmp++; if (read_valid !== 1'b0) begin n_err++; $display("FAIL single_clear: got %b expected 0", read_valid); end
      mem_resp_valid = 1'b1; mem_resp_data = 32'hAB;
      tick();
      mem_resp_valid = 1'b0;
      n_cmp++; if ({resp_valid_1, resp_valid_2, resp_data_1} !== {2'b10, 32'hAB}) begin n_err++; $display("FAIL single_resp: got %b%b/%h expected 10/ab", resp_valid_1, resp_valid_2, resp_data_1); end
      tick();
      n_cmp++; if ({resp_valid_1, resp_valid_2} !== 2'b00) begin n_err++; $display("FAIL single_pulse: got %b expected 00", {resp_valid_1, resp_valid_2}); end
   endtask

   task automatic test_round_robin();
      do_reset();
      req_valid_1 = 1'b1; req_valid_2 = 1'b1;
      for (int i = 0; i < 4; i++) begin
         read_layer_index_1 = 10 + i; read_row_index_1 = 1;
         read_layer_index_2 = 20 + i; read_row_index_2 = 2;
         #1;
         n_cmp++; if ({req_ready_1, req_ready_2} !== ((i % 2 == 0) ? 2'b10 : 2'b01)) begin n_err++; $display("FAIL rr_grant%0d: got %b expected %b", i, {req_ready_1, req_ready_2}, (i % 2 == 0) ? 2'b10 : 2'b01); end
         tick();
         n_cmp++; if (read_layer_index !== ((i % 2 == 0) ? 32'd10 + i : 32'd20 + i)) begin n_err++; $display("FAIL rr_layer%0d: got %0d expected %0d", i, read_layer_index, (i % 2 == 0) ? 10 + i : 20 + i); end
      end
      req_valid_1 = 1'b0; req_valid_2 = 1'b0;
      tick();
      mem_resp_valid = 1'b1;
      for (int i = 0; i < 4; i++) begin
         mem_resp_data = 32'h100 + i;
         tick();
         if (i % 2 == 0) begin
            n_cmp++; if ({resp_valid_1, resp_valid_2, resp_data_1} !== {2'b10, 32'h100 + i}) begin n_err++; $display("FAIL rr_resp%0d: got %b%b/%h expected 10/%h", i, resp_valid_1, resp_valid_2, resp_data_1, 32'h100 + i); end
         end else begin
            n_cmp++; if ({resp_valid_1, resp_valid_2, resp_data_2} !== {2'b01, 32'h100 + i}) begin n_err++; $display("FAIL rr_resp%0d: got %b%b/%h expected 01/%h", i, resp_valid_1, resp_valid_2, resp_data_2, 32'h100 + i); end
         end
      end
      mem_resp_valid = 1'b0;
      tick();
      n_cmp++; if ({resp_valid_1, resp_valid_2, resp_error} !== 3'b000) begin n_err++; $display("FAIL rr_idle: got %b expected 000", {resp_valid_1, resp_valid_2, resp_error}); end
   endtask

   task automatic test_full();
      req_valid_1 = 1'b1; read_layer_index_1 = 1; read_row_index_1 = 1;
      for (int i = 0; i < 4; i++) begin
         #1;
         n_cmp++; if (req_ready_1 !== 1'b1) begin n_err++; $display("FAIL full_grant%0d: got %b expected 1", i, req_ready_1); end
         tick();
      end
      n_cmp++; if (req_ready_1 !== 1'b0) begin n_err++; $display("FAIL full_block: got %b expected 0", req_ready_1); end
      tick();
      n_cmp++; if (req_ready_1 !== 1'b0) begin n_err++; $display("FAIL full_block2: got %b expected 0", req_ready_1); end
      mem_resp_valid = 1'b1; mem_resp_data = 32'h11;
      #1;
      n_cmp++; if (req_ready_1 !== 1'b0) begin n_err++; $display("FAIL full_prepop: got %b expected 0", req_ready_1); end
      tick();
      mem_resp_valid = 1'b0;
      n_cmp++; if (req_ready_1 !== 1'b1) begin n_err++; $display("FAIL full_one_more: got %b expected 1", req_ready_1); end
      tick();
      n_cmp++; if (req_ready_1 !== 1'b0) begin n_err++; $display("FAIL full_again: got %b expected 0", req_ready_1); end
      req_valid_1 = 1'b0;
      mem_resp_valid = 1'b1;
      for (int i = 0; i < 4; i++) begin
         tick();
         n_cmp++; if ({resp_valid_1, resp_valid_2} !== 2'b10) begin n_err++; $display("FAIL full_drain%0d: got %b expected 10", i, {resp_valid_1, resp_valid_2}); end
      end
      mem_resp_valid = 1'b0;
      tick();
   endtask

   task automatic test_back_pressure();
      read_ready = 1'b0;
      req_valid_2 = 1'b1; read_layer_index_2 = 5; read_row_index_2 = 9;
      #1;
      n_cmp++; if ({req_ready_1, req_ready_2} !== 2'b01) begin n_err++; $display("FAIL bp_first: got %b expected 01", {req_ready_1, req_ready_2}); end
      tick();
      req_valid_1 = 1'b1; read_layer_index_1 = 6; read_row_index_1 = 11;
      for (int i = 0; i < 3; i++) begin
         #1;
         n_cmp++; if ({req_ready_1, req_ready_2, read_valid, read_layer_index, read_row_index} !== {3'b001, 32'd5, 32'd9}) begin n_err++; $display("FAIL bp_hold%0d: got %b%b%b/%0d/%0d expected 001/5/9", i, req_ready_1, req_ready_2, read_valid, read_layer_index, read_row_index); end
         tick();
      end
      read_ready = 1'b1;
      #1;
      n_cmp++; if ({req_ready_1, req_ready_2} !== 2'b10) begin n_err++; $display("FAIL bp_release: got %b expected 10", {req_ready_1, req_ready_2}); end
      tick();
      req_valid_1 = 1'b0; req_valid_2 = 1'b0;
      n_cmp++; if ({read_valid, read_layer_index, read_row_index} !== {1'b1, 32'd6, 32'd11}) begin n_err++; $display("FAIL bp_next: got %b/%0d/%0d expected 1/6/11", read_valid, read_layer_index, read_row_index); end
      mem_resp_valid = 1'b1; mem_resp_data = 32'h22;
      tick();
      n_cmp++; if ({resp_valid_1, resp_valid_2, resp_data_2} !== {2'b01, 32'h22}) begin n_err++; $display("FAIL bp_resp_a: got %b%b/%h expected 01/22", resp_valid_1, resp_valid_2, resp_data_2); end
      mem_resp_data = 32'h33;
      tick();
      mem_resp_valid = 1'b0;
      n_cmp++; if ({resp_valid_1, resp_valid_2, resp_data_1} !== {2'b10, 32'h33}) begin n_err++; $display("FAIL bp_resp_b: got %b%b/%h expected 10/33", resp_valid_1, resp_valid_2, resp_data_1); end
      tick();
   endtask

   task automatic test_error();
      mem_resp_valid = 1'b1; mem_resp_data = 32'h55;
      tick();
      mem_resp_valid = 1'b0;
      n_cmp++; if ({resp_error, resp_valid_1, resp_valid_2} !== 3'b100) begin n_err++; $display("FAIL err_set: got %b expected 100", {resp_error, resp_valid_1, resp_valid_2}); end
      tick(); tick();
      n_cmp++; if (resp_error !== 1'b1) begin n_err++; $display("FAIL err_sticky: got %b expected 1", resp_error); end
   endtask

   task automatic test_async_reset();
      req_valid_1 = 1'b1; read_layer_index_1 = 4; read_row_index_1 = 4;
      tick(); tick();
      req_valid_1 = 1'b0;
      rst_n = 1'b0;
      #1;
      n_cmp++; if ({read_valid, resp_valid_1, resp_valid_2, resp_error, read_layer_index, read_row_index} !== 68'h0) begin n_err++; $display("FAIL async_reset: got %b%b%b%b/%0d/%0d expected all 0", read_valid, resp_valid_1, resp_valid_2, resp_error, read_layer_index, read_row_index); end
      tick();
      rst_n = 1'b1;
      req_valid_2 = 1'b1; read_layer_index_2 = 8; read_row_index_2 = 2;
      #1;
      n_cmp++; if ({req_ready_1, req_ready_2} !== 2'b01) begin n_err++; $display("FAIL post_reset_grant: got %b expected 01", {req_ready_1, req_ready_2}); end
      tick();
      req_valid_2 = 1'b0;
      n_cmp++; if ({read_valid, read_layer_index, read_row_index} !== {1'b1, 32'd8, 32'd2}) begin n_err++; $display("FAIL post_reset_loc: got %b/%0d/%0d expected 1/8/2", read_valid, read_layer_index, read_row_index); end
      mem_resp_valid = 1'b1; mem_resp_data = 32'h77;
      tick();
      mem_resp_valid = 1'b0;
      n_cmp++; if ({resp_valid_1, resp_valid_2, resp_data_2, resp_error} !== {2'b01, 32'h77, 1'b0}) begin n_err++; $display("FAIL post_reset_resp: got %b%b/%h/%b expected 01/77/0", resp_valid_1, resp_valid_2, resp_data_2, resp_error); end
   endtask

   initial begin
      test_reset();
      test_single();
      test_round_robin();
      test_full();
      test_back_pressure();
      test_error();
      test_async_reset();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end
endmodule
